// File: rtl/button_debounce.sv
// Button input conditioner: synchronises raw active-low pins, debounces them into a clean
// active-high level, and produces one-cycle press, release and auto-repeat pulses per channel.
module button_debounce #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 4000000,
  parameter int REPEAT_CYCLES   = 800000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] nbtn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_HOLD,
    ST_REPEAT
  } rpt_state_t;

  logic [N_BTN-1:0] r_sync_p0;
  logic [N_BTN-1:0] r_sync_p1;

  logic [N_BTN-1:0] r_level_p2;
  logic [N_BTN-1:0] r_press_p2;
  logic [N_BTN-1:0] r_release_p2;
  logic [N_BTN-1:0] r_repeat_p2;
  logic [DB_W-1:0]  r_dcnt_p2 [N_BTN];
  logic [RPT_W-1:0] r_rcnt_p2 [N_BTN];
  rpt_state_t       r_state_p2 [N_BTN];

  logic [N_BTN-1:0] w_pressed;
  logic [N_BTN-1:0] w_db_done;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_fall;
  logic [DB_W-1:0]  w_dcnt_nxt [N_BTN];
  logic [RPT_W-1:0] w_rcnt_nxt [N_BTN];
  rpt_state_t       w_state_nxt [N_BTN];
  logic [N_BTN-1:0] w_repeat_nxt;

  // Stage p0/p1: two-flop synchroniser; reset value 1 means "released"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_p0 <= '1;
      r_sync_p1 <= '1;
    end else begin
      r_sync_p0 <= nbtn;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Stage p2: debounce counters; w_rise/w_fall mark the edge on which the level flips
  always_comb begin
    w_pressed = ~r_sync_p1;
    w_db_done = '0;
    w_rise    = '0;
    w_fall    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_dcnt_nxt[i] = r_dcnt_p2[i];
      w_db_done[i]  = (w_pressed[i] != r_level_p2[i]) && (r_dcnt_p2[i] == DB_LAST);
      w_rise[i]     = w_db_done[i] & w_pressed[i];
      w_fall[i]     = w_db_done[i] & ~w_pressed[i];
      if (w_pressed[i] == r_level_p2[i]) begin
        w_dcnt_nxt[i] = '0;
      end else if (w_db_done[i]) begin
        w_dcnt_nxt[i] = '0;
      end else begin
        w_dcnt_nxt[i] = r_dcnt_p2[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level_p2   <= '0;
      r_press_p2   <= '0;
      r_release_p2 <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_dcnt_p2[i] <= '0;
      end
    end else begin
      r_level_p2   <= (r_level_p2 & ~w_fall) | w_rise;
      r_press_p2   <= w_rise;
      r_release_p2 <= w_fall;
      for (int i = 0; i < N_BTN; i++) begin
        r_dcnt_p2[i] <= w_dcnt_nxt[i];
      end
    end
  end

  // Repeat FSM: reacts on the same edge as the level flip, so the first repeat lands
  // exactly HOLD_CYCLES after the press pulse; a fall overrides any due repeat
  always_comb begin
    w_repeat_nxt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_state_nxt[i] = r_state_p2[i];
      w_rcnt_nxt[i]  = r_rcnt_p2[i];
      case (r_state_p2[i])
        ST_IDLE: begin
          if (w_rise[i]) begin
            w_state_nxt[i] = ST_WAIT_HOLD;
            w_rcnt_nxt[i]  = '0;
          end
        end
        ST_WAIT_HOLD: begin
          if (r_rcnt_p2[i] == HOLD_LAST) begin
            w_repeat_nxt[i] = 1'b1;
            w_rcnt_nxt[i]   = '0;
            w_state_nxt[i]  = ST_REPEAT;
          end else begin
            w_rcnt_nxt[i] = r_rcnt_p2[i] + RPT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (r_rcnt_p2[i] == RPT_LAST) begin
            w_repeat_nxt[i] = 1'b1;
            w_rcnt_nxt[i]   = '0;
          end else begin
            w_rcnt_nxt[i] = r_rcnt_p2[i] + RPT_W'(1);
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
          w_rcnt_nxt[i]  = '0;
        end
      endcase
      if (w_fall[i]) begin
        w_state_nxt[i]  = ST_IDLE;
        w_rcnt_nxt[i]   = '0;
        w_repeat_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_repeat_p2 <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_state_p2[i] <= ST_IDLE;
        r_rcnt_p2[i]  <= '0;
      end
    end else begin
      r_repeat_p2 <= w_repeat_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        r_state_p2[i] <= w_state_nxt[i];
        r_rcnt_p2[i]  <= w_rcnt_nxt[i];
      end
    end
  end

  assign btn_level   = r_level_p2;
  assign btn_press   = r_press_p2;
  assign btn_release = r_release_p2;
  assign btn_repeat  = r_repeat_p2;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random pin activity, all checked
// every cycle against a window-based behavioural model.
module tb_button_debounce;
  localparam int NB = 2;
  localparam int DC = 4;
  localparam int HC = 10;
  localparam int RC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] nbtn;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_repeat;

  int errors = 0;
  int checks = 0;

  // Model: pin history per edge; level flips once the last DC samples all disagree
  int            cyc = 0;
  logic [NB-1:0] m_d_old, m_d_new;
  logic [NB-1:0] m_level, m_press, m_release, m_repeat;
  bit            m_hist [NB][0:4095];
  int            m_flip [NB];
  int            m_press_cyc [NB];

  button_debounce #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DC), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .nbtn(nbtn), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_d_old   = '1;
    m_d_new   = '1;
    m_level   = '0;
    m_press   = '0;
    m_release = '0;
    m_repeat  = '0;
    for (int ch = 0; ch < NB; ch++) begin
      m_flip[ch]      = cyc;
      m_press_cyc[ch] = -1000;
    end
  endtask

  task automatic model_edge(input logic [NB-1:0] v);
    logic [NB-1:0] pressed;
    bit            all_diff;
    int            age;
    cyc++;
    pressed   = ~m_d_old;
    m_d_old   = m_d_new;
    m_d_new   = v;
    m_press   = '0;
    m_release = '0;
    m_repeat  = '0;
    for (int ch = 0; ch < NB; ch++) begin
      m_hist[ch][cyc] = pressed[ch];
      if (cyc - m_flip[ch] >= DC) begin
        all_diff = 1'b1;
        for (int k = 0; k < DC; k++)
          if (m_hist[ch][cyc-k] == m_level[ch]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[ch] = ~m_level[ch];
          m_flip[ch]  = cyc;
          if (m_level[ch]) begin
            m_press[ch]     = 1'b1;
            m_press_cyc[ch] = cyc;
          end else begin
            m_release[ch] = 1'b1;
          end
        end
      end
      age = cyc - m_press_cyc[ch];
      if (m_level[ch] && !m_press[ch] && age >= HC && ((age - HC) % RC) == 0)
        m_repeat[ch] = 1'b1;
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, "_level"},   btn_level,   m_level);
    chk({where, "_press"},   btn_press,   m_press);
    chk({where, "_release"}, btn_release, m_release);
    chk({where, "_repeat"},  btn_repeat,  m_repeat);
    chk({where, "_press_repeat_overlap"}, btn_press & btn_repeat, '0);
  endtask

  task automatic tick(input logic [NB-1:0] v);
    nbtn = v;
    @(posedge clk);
    model_edge(v);
    #1;
    check_outputs("tick");
  endtask

  task automatic rst_edge();
    @(posedge clk);
    cyc++;
    model_reset();
    #1;
    check_outputs("in_reset");
  endtask

  initial begin
    int            pos, rpos, idx;
    int            reps[$];
    logic          seen, rep_at_rel;
    logic [NB-1:0] pv, rv, cur, v;

    rst  = 1'b1;
    nbtn = '1;
    model_reset();
    #1;
    check_outputs("reset");
    rst_edge();
    rst_edge();
    #2 rst = 1'b0;

    // Clean press and release on channel 0
    for (int k = 0; k < 8; k++) tick(2'b11);
    pos = -1;
    for (int k = 1; k <= 12; k++) begin
      tick(2'b10);
      if (pos < 0 && btn_press[0]) pos = k;
    end
    chk("press_latency", pos, 6);
    chk("press_ch1_level", {31'd0, btn_level[1]}, 0);
    pos = -1;
    for (int k = 1; k <= 12; k++) begin
      tick(2'b11);
      if (pos < 0 && btn_release[0]) pos = k;
    end
    chk("release_latency", pos, 6);

    // Bounce: low 3, high 1, low 3, then high
    seen = 1'b0;
    for (int k = 0; k < 19; k++) begin
      v = (k < 3 || (k >= 4 && k < 7)) ? 2'b10 : 2'b11;
      tick(v);
      seen = seen | btn_press[0] | btn_release[0] | btn_level[0];
    end
    chk("bounce_quiet", {31'd0, seen}, 0);

    // Auto-repeat, then a release whose fall lands on a repeat-due cycle
    pos = -1;
    for (int k = 1; k <= 12 && pos < 0; k++) begin
      tick(2'b10);
      if (btn_press[0]) pos = k;
    end
    chk("rpt_press_latency", pos, 6);
    for (int off = 1; off <= 31; off++) begin
      tick(2'b10);
      if (btn_repeat[0]) reps.push_back(off);
    end
    rpos = -1;
    rep_at_rel = 1'bx;
    for (int k = 1; k <= 12; k++) begin
      tick(2'b11);
      if (btn_repeat[0]) reps.push_back(31 + k);
      if (btn_release[0]) begin
        rpos = 31 + k;
        rep_at_rel = btn_repeat[0];
      end
    end
    chk("rpt_count", reps.size(), 9);
    for (int i = 0; i < reps.size() && i < 9; i++) chk("rpt_offset", reps[i], 10 + 3 * i);
    chk("rel_offset", rpos, 37);
    chk("rel_no_repeat", {31'd0, rep_at_rel}, 0);

    // Both channels pressed together, channel 1 released alone
    for (int k = 0; k < 6; k++) tick(2'b11);
    pos = -1;
    pv  = '0;
    for (int k = 1; k <= 12 && pos < 0; k++) begin
      tick(2'b00);
      if (btn_press != '0) begin
        pos = k;
        pv  = btn_press;
      end
    end
    chk("simul_press", pv, 2'b11);
    chk("simul_latency", pos, 6);
    for (int k = 0; k < 4; k++) tick(2'b00);
    rv = '0;
    for (int k = 1; k <= 12 && rv == '0; k++) begin
      tick(2'b10);
      rv = btn_release;
    end
    chk("simul_release", rv, 2'b10);
    chk("simul_ch0_held", {31'd0, btn_level[0]}, 1);

    // Asynchronous reset while channel 0 is auto-repeating
    for (int k = 0; k < 20 && !btn_repeat[0]; k++) tick(2'b10);
    chk("pre_reset_repeat", {31'd0, btn_repeat[0]}, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    rst_edge();
    rst_edge();
    #2 rst = 1'b0;
    pos = -1;
    for (int k = 1; k <= 12 && pos < 0; k++) begin
      tick(2'b10);
      if (btn_press[0]) pos = k;
    end
    chk("post_rst_press", pos, 6);
    pos = -1;
    for (int k = 1; k <= 15 && pos < 0; k++) begin
      tick(2'b10);
      if (btn_repeat[0]) pos = k;
    end
    chk("post_rst_first_repeat", pos, 10);

    // Random pin activity: fast chatter, then slower holds that reach auto-repeat
    cur = 2'b11;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, NB - 1);
        cur[idx] = ~cur[idx];
      end
      tick(cur);
    end
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        idx = $urandom_range(0, NB - 1);
        cur[idx] = ~cur[idx];
      end
      tick(cur);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Multi-channel input conditioner between the badge's raw active-low button pins (nbtn) and the stopwatch/UI control logic.
- Per channel:
  - synchronises the asynchronous pin;
  - debounces it into a clean active-high level;
  - emits one-cycle press, release and auto-repeat pulses.
- Control logic uses these outputs instead of sampling the inverted pins directly.
- Gives edge-triggered start/stop/lap with no bounce-induced double actions.

Parameters:
- N_BTN, 8, number of independent button channels.
- DEBOUNCE_CYCLES, 20000, consecutive stable samples required to accept a level change (2.5 ms at 8 MHz); must be >= 2.
- HOLD_CYCLES, 4000000, cycles from press pulse to first repeat pulse (0.5 s); must be >= 2.
- REPEAT_CYCLES, 800000, cycles between subsequent repeat pulses (0.1 s); must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- nbtn  in  N_BTN  raw button pins, active-low, asynchronous to clk
- btn_level  out  N_BTN  debounced level, 1 = pressed
- btn_press  out  N_BTN  one-cycle pulse on debounced 0->1
- btn_release  out  N_BTN  one-cycle pulse on debounced 1->0
- btn_repeat  out  N_BTN  one-cycle auto-repeat pulse while held

Behaviour:
- Reset, while rst is high (asynchronous):
  - synchroniser flops = 1 (released);
  - debounce counters = 0; repeat counters = 0;
  - repeat FSM = IDLE;
  - btn_level, btn_press, btn_release, btn_repeat = 0.
- Synchroniser: 2-flop chain per channel. The sampled value is pressed = ~sync2.
- Debounce, per channel:
  - If pressed == btn_level: counter <= 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1: btn_level <= pressed and counter <= 0.
  - Otherwise: counter <= counter+1.
  - Counter width: clog2(DEBOUNCE_CYCLES).
  - Any sample equal to the current level restarts the count. A bounce shorter than DEBOUNCE_CYCLES never changes btn_level.
- Latency:
  - The new btn_level is visible DEBOUNCE_CYCLES+2 clock edges after nbtn settles. The first edge that captures the new pin value counts as edge 1.
  - btn_press / btn_release are registered and assert in the same cycle btn_level changes. They are high for exactly one cycle.
- Repeat FSM, per channel, with a counter of width clog2(max(HOLD_CYCLES, REPEAT_CYCLES)):
  - IDLE: on debounced rise -> WAIT_HOLD, counter <= 0.
  - WAIT_HOLD: counter increments each cycle. At HOLD_CYCLES-1: btn_repeat pulse, counter <= 0, -> REPEAT. The first repeat is therefore visible HOLD_CYCLES cycles after the press pulse.
  - REPEAT: counter increments. At REPEAT_CYCLES-1: btn_repeat pulse, counter <= 0. Pulses recur every REPEAT_CYCLES cycles.
  - Debounced fall in any state -> IDLE, counter <= 0.
  - Release has priority: no btn_repeat in the cycle btn_release asserts, even if the counter matches.
- btn_press and btn_repeat are never high in the same cycle.
- Channels are fully independent. Simultaneous events on several channels give simultaneous pulses, and state is not shared between channels.
- Reset mid-operation:
  - All pulses drop immediately; any pending debounce or repeat is discarded.
  - A button still held when rst deasserts is treated as a fresh press. btn_press fires DEBOUNCE_CYCLES+2 edges after rst falls.
- Counters never wrap. Each is explicitly cleared at its terminal value.

Test Plan (N_BTN=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3):
- Clean press: nbtn[0] 1->0 held -> btn_level[0] and a 1-cycle btn_press[0] appear on edge 6 after the change; btn_level[1] stays 0.
- Bounce rejection: nbtn[0] low for 3 cycles, high 1, low 3, high -> btn_level[0] never rises; no btn_press or btn_release pulse.
- Auto-repeat: hold nbtn[0] low for 30 cycles after the press pulse -> btn_repeat[0] at +10, +13, +16, ..., +28 cycles; never coincident with btn_press.
- Release priority: release timed so the debounced fall lands on a repeat-due cycle -> btn_release[0] = 1 and btn_repeat[0] = 0 that cycle; FSM IDLE; no further repeats.
- Simultaneous channels: nbtn = 2'b11 -> 2'b00 on the same edge -> btn_press = 2'b11 in one cycle; releasing only channel 1 later -> btn_release = 2'b10.
- Reset mid-hold: assert rst asynchronously while in REPEAT -> all outputs 0 at once. Deassert with the button still low -> btn_press fires again 6 edges later; first repeat 10 cycles after that.
